// File: rtl/battleship_pkg.sv
// Shared types for the battleship grid: cell, shot-result and phase encodings.
package battleship_pkg;

  typedef enum logic [1:0] {
    CellEmpty = 2'd0,
    CellShip  = 2'd1,
    CellMiss  = 2'd2,
    CellHit   = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    ResMiss    = 2'd0,
    ResHit     = 2'd1,
    ResRepeat  = 2'd2,
    ResInvalid = 2'd3
  } result_t;

  typedef enum logic [1:0] {
    PhPlace = 2'd0,
    PhPlay  = 2'd1,
    PhOver  = 2'd2
  } phase_t;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/battleship_coord_check.sv
// Range check and row-major flattening of a (row, col) board coordinate.
module battleship_coord_check #(
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 5,
  parameter int unsigned ROW_W = 3,
  parameter int unsigned COL_W = 3,
  parameter int unsigned IDX_W = 5
) (
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] col_i,
  output logic             in_range_o,
  output logic [IDX_W-1:0] idx_o
);

  assign in_range_o = (32'(row_i) < ROWS) && (32'(col_i) < COLS);
  // Only meaningful when in_range_o is set.
  assign idx_o      = IDX_W'(32'(row_i) * COLS + 32'(col_i));

endmodule

// File: rtl/battleship_grid.sv
// Battleship board: ship placement phase, single-cycle shot resolution with a
// one-cycle result pulse, and game-over detection.
module battleship_grid
  import battleship_pkg::*;
#(
  parameter int unsigned ROWS           = 5,
  parameter int unsigned COLS           = 5,
  parameter int unsigned MAX_SHIP_CELLS = 8,
  localparam int unsigned ROW_W         = idx_width(ROWS),
  localparam int unsigned COL_W         = idx_width(COLS),
  localparam int unsigned CNT_W         = $clog2(MAX_SHIP_CELLS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   place_valid,
  input  logic                   place_done,
  input  logic                   shoot_valid,
  output logic                   shoot_ready,
  input  logic [ROW_W-1:0]       row,
  input  logic [COL_W-1:0]       col,
  output logic                   result_valid,
  output logic [1:0]             result,
  output logic [CNT_W-1:0]       ships_left,
  output logic [15:0]            shot_count,
  output logic [1:0]             phase,
  output logic                   game_over,
  output logic [2*ROWS*COLS-1:0] board
);

  localparam int unsigned NCELLS = ROWS * COLS;
  localparam int unsigned IDX_W  = idx_width(NCELLS);
  localparam logic [CNT_W-1:0] MaxCells = CNT_W'(MAX_SHIP_CELLS);

  logic             in_range;
  logic [IDX_W-1:0] idx;

  battleship_coord_check #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .IDX_W (IDX_W)
  ) u_coord (
    .row_i      (row),
    .col_i      (col),
    .in_range_o (in_range),
    .idx_o      (idx)
  );

  cell_t            cells_q [NCELLS];
  cell_t            cells_d [NCELLS];
  logic [CNT_W-1:0] ships_q, ships_d;
  logic [15:0]      count_q, count_d;
  phase_t           phase_q, phase_d;
  result_t          result_q, result_d;
  logic             rv_q, rv_d;
  cell_t            cur_cell;

  assign cur_cell = in_range ? cells_q[idx] : CellEmpty;

  always_comb begin
    cells_d  = cells_q;
    ships_d  = ships_q;
    count_d  = count_q;
    phase_d  = phase_q;
    result_d = result_q;
    rv_d     = 1'b0;

    unique case (phase_q)
      PhPlace: begin
        if (place_valid && in_range && (cur_cell == CellEmpty) && (ships_q < MaxCells)) begin
          cells_d[idx] = CellShip;
          ships_d      = ships_q + CNT_W'(1);
        end
        // A placement accepted this cycle already counts toward leaving PLACE.
        if (place_done && (ships_d != '0)) begin
          phase_d = PhPlay;
        end
      end
      PhPlay: begin
        if (shoot_valid) begin
          rv_d = 1'b1;
          if (!in_range) begin
            result_d = ResInvalid;
          end else begin
            unique case (cur_cell)
              CellEmpty: begin
                cells_d[idx] = CellMiss;
                result_d     = ResMiss;
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
              end
              CellShip: begin
                cells_d[idx] = CellHit;
                result_d     = ResHit;
                ships_d      = ships_q - CNT_W'(1);
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                if (ships_q == CNT_W'(1)) phase_d = PhOver;
              end
              CellMiss, CellHit: begin
                result_d = ResRepeat;
              end
              default: result_d = ResRepeat;
            endcase
          end
        end
      end
      PhOver: begin
        phase_d = PhOver;
      end
      default: phase_d = phase_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCELLS; i++) cells_q[i] <= CellEmpty;
      ships_q  <= '0;
      count_q  <= '0;
      phase_q  <= PhPlace;
      result_q <= ResMiss;
      rv_q     <= 1'b0;
    end else begin
      cells_q  <= cells_d;
      ships_q  <= ships_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  always_comb begin
    board = '0;
    for (int unsigned i = 0; i < NCELLS; i++) board[2*i +: 2] = cells_q[i];
  end

  assign shoot_ready  = (phase_q == PhPlay);
  // A reset arriving in the result cycle suppresses the pending pulse.
  assign result_valid = rv_q & rst;
  assign result       = result_q;
  assign ships_left   = ships_q;
  assign shot_count   = count_q;
  assign phase        = phase_q;
  assign game_over    = (phase_q == PhOver);

endmodule

// File: tb/tb_battleship_grid.sv
// Self-checking bench for battleship_grid: directed table, corner sequences and
// randomized play against a cell-array reference model.
module tb_battleship_grid;

  localparam int R = 5;
  localparam int C = 5;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, place_valid = 1'b0, place_done = 1'b0, shoot_valid = 1'b0;
  logic [2:0]  row = '0, col = '0;
  logic        shoot_ready, result_valid, game_over;
  logic [1:0]  result, phase;
  logic [3:0]  ships_left;
  logic [15:0] shot_count;
  logic [49:0] board;

  logic        rst2 = 1'b0, pv2 = 1'b0, pd2 = 1'b0, sv2 = 1'b0;
  logic [2:0]  row2 = '0, col2 = '0;
  logic        sr2, rv2, go2;
  logic [1:0]  res2, phase2;
  logic [1:0]  ships2;
  logic [15:0] cnt2;
  logic [49:0] board2;

  battleship_grid dut (
    .clk(clk), .rst(rst), .place_valid(place_valid), .place_done(place_done),
    .shoot_valid(shoot_valid), .shoot_ready(shoot_ready), .row(row), .col(col),
    .result_valid(result_valid), .result(result), .ships_left(ships_left),
    .shot_count(shot_count), .phase(phase), .game_over(game_over), .board(board)
  );

  battleship_grid #(.MAX_SHIP_CELLS(2)) dut2 (
    .clk(clk), .rst(rst2), .place_valid(pv2), .place_done(pd2),
    .shoot_valid(sv2), .shoot_ready(sr2), .row(row2), .col(col2),
    .result_valid(rv2), .result(res2), .ships_left(ships2),
    .shot_count(cnt2), .phase(phase2), .game_over(go2), .board(board2)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // op: 0 idle, 1 place, 2 place_done, 3 shoot
  task automatic drive(input int op, input int r, input int c);
    place_valid = (op == 1);
    place_done  = (op == 2);
    shoot_valid = (op == 3);
    row = 3'(r);
    col = 3'(c);
  endtask

  // Reference model: board as a 2-D array of cell codes, plain counters.
  int mb[R][C];
  int mships, mcount, mphase, mres;
  bit mrv;

  function automatic void model_reset();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) mb[r][c] = 0;
    mships = 0; mcount = 0; mphase = 0; mres = 0; mrv = 0;
  endfunction

  function automatic void model_apply(bit pv, bit pd, bit sv, int r, int c);
    bit inr;
    inr = (r < R) && (c < C);
    mrv = 0;
    if (mphase == 0) begin
      if (pv && inr && mb[r][c] == 0 && mships < 8) begin
        mb[r][c] = 1;
        mships++;
      end
      if (pd && mships > 0) mphase = 1;
    end else if (mphase == 1 && sv) begin
      mrv = 1;
      if (!inr) mres = 3;
      else if (mb[r][c] == 0) begin
        mb[r][c] = 2; mres = 0;
        if (mcount < 65535) mcount++;
      end else if (mb[r][c] == 1) begin
        mb[r][c] = 3; mres = 1; mships--;
        if (mcount < 65535) mcount++;
        if (mships == 0) mphase = 2;
      end else mres = 2;
    end
  endfunction

  function automatic logic [63:0] model_board();
    logic [63:0] b;
    b = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) b[2*(r*C+c) +: 2] = 2'(mb[r][c]);
    return b;
  endfunction

  task automatic check_all(input string tag);
    check({tag, " result_valid"}, 64'(result_valid), 64'(mrv));
    check({tag, " result"}, 64'(result), 64'(mres));
    check({tag, " ships_left"}, 64'(ships_left), 64'(mships));
    check({tag, " shot_count"}, 64'(shot_count), 64'(mcount));
    check({tag, " phase"}, 64'(phase), 64'(mphase));
    check({tag, " game_over"}, 64'(game_over), 64'(mphase == 2));
    check({tag, " shoot_ready"}, 64'(shoot_ready), 64'(mphase == 1));
    check({tag, " board"}, 64'(board), model_board());
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int op; int r; int c;
    bit ev; int er; int es; int ep; int ecnt;
  } vec_t;

  vec_t tbl[16];
  logic [63:0] exp_b;

  initial begin
    // op, row, col, result_valid, result, ships_left, phase, shot_count
    tbl[0]  = '{2, 0, 0, 0, 0, 0, 0, 0}; // done with no ships: stays PLACE
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 1, 0, 0}; // occupied
    tbl[3]  = '{1, 7, 1, 0, 0, 1, 0, 0}; // out of range
    tbl[4]  = '{1, 0, 1, 0, 0, 2, 0, 0};
    tbl[5]  = '{2, 0, 0, 0, 0, 2, 1, 0};
    tbl[6]  = '{1, 2, 2, 0, 0, 2, 1, 0}; // place ignored in PLAY
    tbl[7]  = '{3, 0, 0, 1, 1, 1, 1, 1}; // HIT
    tbl[8]  = '{0, 0, 0, 0, 1, 1, 1, 1}; // result holds
    tbl[9]  = '{3, 4, 4, 1, 0, 1, 1, 2}; // MISS
    tbl[10] = '{3, 4, 4, 1, 2, 1, 1, 2}; // REPEAT
    tbl[11] = '{3, 7, 0, 1, 3, 1, 1, 2}; // INVALID
    tbl[12] = '{3, 0, 0, 1, 2, 1, 1, 2}; // REPEAT on HIT
    tbl[13] = '{3, 0, 1, 1, 1, 0, 2, 3}; // last ship sunk
    tbl[14] = '{3, 1, 1, 0, 1, 0, 2, 3}; // no result in OVER
    tbl[15] = '{2, 0, 0, 0, 1, 0, 2, 3};

    do_reset();
    check("reset result_valid", 64'(result_valid), 64'd0);
    check("reset phase", 64'(phase), 64'd0);
    check("reset ships_left", 64'(ships_left), 64'd0);
    check("reset board", 64'(board), 64'd0);
    check("reset shoot_ready", 64'(shoot_ready), 64'd0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].op, tbl[i].r, tbl[i].c);
      step();
      check($sformatf("tbl%0d result_valid", i), 64'(result_valid), 64'(tbl[i].ev));
      check($sformatf("tbl%0d result", i), 64'(result), 64'(tbl[i].er));
      check($sformatf("tbl%0d ships_left", i), 64'(ships_left), 64'(tbl[i].es));
      check($sformatf("tbl%0d phase", i), 64'(phase), 64'(tbl[i].ep));
      check($sformatf("tbl%0d shot_count", i), 64'(shot_count), 64'(tbl[i].ecnt));
      check($sformatf("tbl%0d game_over", i), 64'(game_over), 64'(tbl[i].ep == 2));
      check($sformatf("tbl%0d shoot_ready", i), 64'(shoot_ready), 64'(tbl[i].ep == 1));
    end
    drive(0, 0, 0);
    exp_b = '0;
    exp_b[1:0]   = 2'd3;
    exp_b[3:2]   = 2'd3;
    exp_b[49:48] = 2'd2;
    check("tbl final board", 64'(board), exp_b);

    // Reset in the cycle after an accepted shot discards the result.
    do_reset();
    drive(1, 1, 1); step();
    drive(2, 0, 0); step();
    drive(3, 1, 1); step();
    rst = 1'b0;
    drive(0, 0, 0);
    #2;
    check("rst-after-shot rv early", 64'(result_valid), 64'd0);
    @(negedge clk);
    check("rst-after-shot rv mid", 64'(result_valid), 64'd0);
    step();
    check("rst-after-shot rv", 64'(result_valid), 64'd0);
    check("rst-after-shot board", 64'(board), 64'd0);
    check("rst-after-shot phase", 64'(phase), 64'd0);
    check("rst-after-shot ships", 64'(ships_left), 64'd0);
    rst = 1'b1;
    step();
    check("rst-after-shot rv after", 64'(result_valid), 64'd0);

    // MAX_SHIP_CELLS=2 instance: placement limit and empty place_done.
    rst2 = 1'b0; step(); step(); rst2 = 1'b1;
    pd2 = 1'b1; step(); pd2 = 1'b0;
    check("max2 empty done phase", 64'(phase2), 64'd0);
    pv2 = 1'b1;
    row2 = 3'd0; col2 = 3'd0; step();
    row2 = 3'd1; col2 = 3'd1; step();
    row2 = 3'd2; col2 = 3'd2; step();
    pv2 = 1'b0;
    check("max2 ships_left", 64'(ships2), 64'd2);
    exp_b = '0;
    exp_b[1:0]   = 2'd1;
    exp_b[13:12] = 2'd1;
    check("max2 board", 64'(board2), exp_b);
    rst2 = 1'b0; step(); rst2 = 1'b1;
    pv2 = 1'b1; pd2 = 1'b1; row2 = 3'd3; col2 = 3'd3; step();
    pv2 = 1'b0; pd2 = 1'b0;
    check("max2 place+done phase", 64'(phase2), 64'd1);
    check("max2 place+done ships", 64'(ships2), 64'd1);
    check("max2 place+done ready", 64'(sr2), 64'd1);

    // Randomized games against the reference model.
    for (int g = 0; g < 4; g++) begin
      int extra;
      do_reset();
      check_all("rand reset");
      extra = 0;
      for (int cyc = 0; cyc < 600 && extra < 3; cyc++) begin
        bit pv, pd, sv;
        int r, c;
        pv = 1'($urandom_range(0, 1));
        pd = ($urandom_range(0, 7) == 0);
        sv = ($urandom_range(0, 3) != 0);
        r  = $urandom_range(0, 5);
        c  = $urandom_range(0, 5);
        place_valid = pv; place_done = pd; shoot_valid = sv;
        row = 3'(r); col = 3'(c);
        model_apply(pv, pd, sv, r, c);
        step();
        check_all($sformatf("rand g%0d c%0d", g, cyc));
        if (mphase == 2) extra++;
      end
    end
    drive(0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/battleship_grid.md
BATTLESHIP_GRID -- requirements
Module: battleship_grid

Interface
REQ-001 SHALL have parameter ROWS, default 5, board row count (1..16).
REQ-002 SHALL have parameter COLS, default 5, board column count (1..16).
REQ-003 SHALL have parameter MAX_SHIP_CELLS, default 8, upper limit on placed ship cells (1..ROWS*COLS).
REQ-004 SHALL derive ROW_W = max(1,clog2(ROWS)), COL_W = max(1,clog2(COLS)) and CNT_W = clog2(MAX_SHIP_CELLS+1).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset; synchronous, active-low.
REQ-007 place_valid  input  1  request to place a ship cell at row/col.
REQ-008 place_done  input  1  end placement, start play.
REQ-009 shoot_valid  input  1  shot request at row/col.
REQ-010 shoot_ready  output  1  shot acceptance (high only in PLAY).
REQ-011 row  input  ROW_W  target row for place or shoot.
REQ-012 col  input  COL_W  target column for place or shoot.
REQ-013 result_valid  output  1  one-cycle pulse qualifying result.
REQ-014 result  output  2  shot outcome: MISS=0, HIT=1, REPEAT=2, INVALID=3.
REQ-015 ships_left  output  CNT_W  count of unhit SHIP cells.
REQ-016 shot_count  output  16  accepted MISS/HIT shots, saturating.
REQ-017 phase  output  2  PLACE=0, PLAY=1, OVER=2.
REQ-018 game_over  output  1  high while phase is OVER.
REQ-019 board  output  2*ROWS*COLS  cell states; cell (r,c) at bits [2*(r*COLS+c) +: 2]; EMPTY=0, SHIP=1, MISS=2, HIT=3.

Function
REQ-020 Phase FSM SHALL be PLACE -> PLAY -> OVER; OVER is left only by reset.
REQ-021 In PLACE, place_valid with row<ROWS, col<COLS, cell EMPTY and ships_left<MAX_SHIP_CELLS SHALL set cell to SHIP and increment ships_left at the next edge.
REQ-022 In PLACE, place_valid on an out-of-range, non-EMPTY cell, or with ships_left==MAX_SHIP_CELLS SHALL be ignored with no state change.
REQ-023 In PLACE, place_done with ships_left>0 (counting a placement accepted the same cycle) SHALL move phase to PLAY at the next edge; with zero cells it SHALL be ignored.
REQ-024 place_valid and place_done SHALL be ignored outside PLACE.
REQ-025 shoot_ready SHALL equal (phase==PLAY) combinationally; a shot is accepted when shoot_valid && shoot_ready.
REQ-026 Accepted shot SHALL produce result_valid=1 for exactly one cycle starting the cycle after acceptance (latency 1); one shot may be accepted every cycle.
REQ-027 Shot on in-range EMPTY cell SHALL set it MISS and report MISS; on SHIP SHALL set it HIT, decrement ships_left, report HIT.
REQ-028 Shot on MISS or HIT cell SHALL report REPEAT with no board or counter change.
REQ-029 Shot with row>=ROWS or col>=COLS SHALL report INVALID with no board or counter change.
REQ-030 shot_count SHALL increment on MISS and HIT results only, saturating at 16'hFFFF.
REQ-031 A HIT that brings ships_left to 0 SHALL move phase to OVER on the same edge that asserts result_valid; game_over rises with that result.
REQ-032 In OVER, shoot_ready=0 and board, ships_left and shot_count SHALL hold.
REQ-033 result SHALL hold its last value when result_valid is low.

Reset
REQ-034 rst low at a rising edge SHALL set every cell EMPTY, phase PLACE, ships_left 0, shot_count 0, result 0, result_valid 0, game_over 0.
REQ-035 Reset asserted the cycle after a shot acceptance SHALL take priority; the pending result is discarded (result_valid stays 0).

Structure
REQ-036 Package battleship_pkg SHALL hold cell_t (EMPTY/SHIP/MISS/HIT), result_t (MISS/HIT/REPEAT/INVALID) and phase_t (PLACE/PLAY/OVER) enums.
REQ-037 Sub-module battleship_coord_check SHALL compute the in-range flag and flat cell index from row/col; everything else stays in battleship_grid.

Verification
REQ-038 Place (0,0),(0,1), place_done, shoot (0,0) -> next cycle result_valid=1, result=HIT, ships_left=1, cell(0,0)=HIT.
REQ-039 Shoot (4,4) twice on EMPTY cell -> MISS then REPEAT; shot_count=1.
REQ-040 Defaults, shoot row=7 -> INVALID, board unchanged, shot_count unchanged.
REQ-041 MAX_SHIP_CELLS=2, place three distinct cells -> ships_left=2, third cell EMPTY; place_done with zero cells after reset -> phase stays PLACE.
REQ-042 Sink last ship cell -> result=HIT, game_over=1 same cycle, shoot_ready=0 next cycle; further shoot_valid produces no result.
REQ-043 Reset (rst=0) one cycle after accepted shot -> result_valid never pulses, board all EMPTY, phase PLACE.
